pipe_skid_buffer: RTL and testbench
===================================

// Module: pipe_skid_buffer
// PURPOSE
//   Two-entry valid/ready skid buffer placed in front of each pipeline register stage.
//   Cuts the combinational ready path between stages: o_ready depends only on internal state.
//   Sustains one transfer per cycle, preserves order, and supports a synchronous pipeline flush.
// PARAMETERS
//   DATA_WIDTH  32  width of the payload carried through the stage
// PORTS
//   clk      in   1           clock, all state updates on rising edge
//   rst      in   1           reset, asynchronous, active-low (0 = reset)
//   i_flush  in   1           synchronous flush, discards all held entries
//   i_valid  in   1           upstream has data on i_data
//   o_ready  out  1           stage can accept data this cycle
//   i_data   in   DATA_WIDTH  upstream payload
//   o_valid  out  1           o_data holds a valid entry
//   i_ready  in   1           downstream accepts o_data this cycle
//   o_data   out  DATA_WIDTH  payload to downstream (pipeline register input)
// BEHAVIOUR
//   - Accept: in_fire = i_valid & o_ready. Emit: out_fire = o_valid & i_ready.
//   - Storage: main register (drives o_data) and skid register. No combinational path
//     from i_data/i_valid to o_data/o_valid, or from i_ready to o_ready.
//   - States: EMPTY (0 entries), BUSY (main valid), FULL (main + skid valid).
//   - o_valid = (state != EMPTY); o_ready = (state != FULL). Both decoded from state flops only.
//   - EMPTY: in_fire -> main<=i_data, BUSY. Else stay.
//   - BUSY:  in_fire & out_fire -> main<=i_data, BUSY.
//            in_fire only -> skid<=i_data, FULL.
//            out_fire only -> EMPTY.  Neither -> hold.
//   - FULL:  out_fire -> main<=skid, BUSY. Else hold. o_ready=0, so no accept.
//   - Latency: data accepted in cycle N appears on o_data with o_valid=1 in cycle N+1.
//   - Throughput: one beat per cycle with i_ready held 1. FULL is reached only
//     when downstream stalls.
//   - Stability: while o_valid=1 and i_ready=0, o_data and o_valid hold unchanged.
//   - i_data is ignored whenever o_ready=0. i_valid while FULL is not lost.
//     Upstream must hold it, per standard valid/ready.
//   - Ordering: strict FIFO. The skid entry is always emitted after the main entry.
//   - Flush: i_flush=1 at edge -> state EMPTY next cycle.
//     It takes priority over in_fire/out_fire in that cycle. The beat presented with
//     i_flush is dropped. main/skid data hold their values (don't-care).
//     Downstream still sees out_fire that cycle if o_valid & i_ready; the flush does not
//     retract a completed handshake.
//   - Reset (rst=0, any time, incl. mid-transfer): immediately state EMPTY, o_valid=0,
//     o_ready=1, main=0, skid=0, o_data=0. First accept on first edge after rst=1.
//   - Width: payload passed bit-exact, no arithmetic.
// TESTING
//   1. Reset: rst=0 mid-run with FULL state -> o_valid=0, o_ready=1, o_data=0 without a clock edge.
//   2. Streaming: i_valid=1, i_ready=1, data 0x11,0x22,0x33 on consecutive cycles
//      -> o_data 0x11,0x22,0x33 one cycle later each, o_ready stays 1.
//   3. Stall fill: send 0xA5, then 0x3C with i_ready=0 -> BUSY, then FULL, o_ready=0.
//      Present 0xFF, held, for 2 cycles: not accepted. Raise i_ready -> out 0xA5, 0x3C, then 0xFF.
//   4. Simultaneous: in BUSY with o_data=0x55, i_valid=1 (0x66) & i_ready=1
//      -> next o_data=0x66, state BUSY, no FULL.
//   5. Flush: FULL with 0x01/0x02, assert i_flush one cycle, i_valid=1 (0x03)
//      -> next cycle o_valid=0, o_ready=1. 0x03 is not emitted.
//   6. Order check: random i_valid/i_ready for 1000 cycles against a reference queue
//      -> every emitted word matches in order, no loss or duplication.

Source files
------------

// File: rtl/pipe_skid_buffer.sv
// Two-entry valid/ready skid buffer: a main register drives the output, a skid
// register absorbs the beat accepted while downstream stalls.
//
//   state | meaning
//   EMPTY | no entries held
//   BUSY  | main holds the next beat to emit
//   FULL  | main and skid both hold beats; skid is the younger one
module pipe_skid_buffer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] main_q, skid_q;
  logic                  in_fire, out_fire;
  logic                  load_main_in, load_main_skid, load_skid;

  // Handshake outputs come from state flops only, cutting the ready path.
  assign o_valid  = (state != EMPTY);
  assign o_ready  = (state != FULL);
  assign o_data   = main_q;
  assign in_fire  = i_valid & o_ready;
  assign out_fire = o_valid & i_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          load_main_in = 1'b1;
          state_next   = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end else if (in_fire) begin
          load_skid  = 1'b1;
          state_next = FULL;
        end else if (out_fire) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          load_main_skid = 1'b1;
          state_next     = BUSY;
        end
      end
      default: state_next = EMPTY;
    endcase
    // Flush wins over any accept; data registers keep stale contents.
    if (i_flush) begin
      state_next     = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in) begin
        main_q <= i_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= i_data;
      end
    end
  end

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Self-checking bench for pipe_skid_buffer: directed scenarios plus a randomized
// run against a capacity-2 FIFO reference model.
module tb_pipe_skid_buffer;

  logic        clk;
  logic        rst;
  logic        i_flush;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_data;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_data;

  int total = 0;
  int bad   = 0;
  logic [31:0] mq[$];

  pipe_skid_buffer #(.DATA_WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_flush (i_flush),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs, advance one edge, update the FIFO model, settle.
  task automatic tick(input logic v, input logic [31:0] d, input logic r, input logic f);
    logic in_f, out_f;
    i_valid = v;
    i_data  = d;
    i_ready = r;
    i_flush = f;
    in_f  = v && (mq.size() < 2);
    out_f = (mq.size() > 0) && r;
    @(posedge clk);
    if (f) begin
      mq.delete();
    end else begin
      if (out_f) void'(mq.pop_front());
      if (in_f) mq.push_back(d);
    end
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    i_valid = 0; i_data = 0; i_ready = 0; i_flush = 0;
    #12;
    total++; if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_data !== 32'h0) begin
      bad++; $display("FAIL reset_init: valid=%b ready=%b data=%h want 0 1 0", o_valid, o_ready, o_data);
    end
    @(negedge clk); rst = 1'b1; mq.delete();
    tick(1, 32'hAA, 0, 0);
    tick(1, 32'hBB, 0, 0);
    total++; if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_data !== 32'hAA) begin
      bad++; $display("FAIL reset_fill: ready=%b valid=%b data=%h want 0 1 aa", o_ready, o_valid, o_data);
    end
    #2 rst = 1'b0;
    #1;
    total++; if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_data !== 32'h0) begin
      bad++; $display("FAIL reset_async: valid=%b ready=%b data=%h want 0 1 0", o_valid, o_ready, o_data);
    end
    @(negedge clk); rst = 1'b1; mq.delete();
  endtask

  task automatic test_streaming;
    logic [31:0] words[3];
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
    for (int k = 0; k < 3; k++) begin
      tick(1, words[k], 1, 0);
      total++; if (o_valid !== 1'b1 || o_data !== words[k] || o_ready !== 1'b1) begin
        bad++; $display("FAIL stream_%0d: valid=%b data=%h ready=%b want 1 %h 1", k, o_valid, o_data, o_ready, words[k]);
      end
    end
    tick(0, 0, 1, 0);
    total++; if (o_valid !== 1'b0) begin
      bad++; $display("FAIL stream_drain: valid=%b want 0", o_valid);
    end
  endtask

  task automatic test_stall_fill;
    tick(1, 32'hA5, 0, 0);
    total++; if (o_valid !== 1'b1 || o_data !== 32'hA5 || o_ready !== 1'b1) begin
      bad++; $display("FAIL stall_busy: valid=%b data=%h ready=%b want 1 a5 1", o_valid, o_data, o_ready);
    end
    tick(1, 32'h3C, 0, 0);
    total++; if (o_ready !== 1'b0 || o_data !== 32'hA5) begin
      bad++; $display("FAIL stall_full: ready=%b data=%h want 0 a5", o_ready, o_data);
    end
    for (int k = 0; k < 2; k++) begin
      tick(1, 32'hFF, 0, 0);
      total++; if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_data !== 32'hA5) begin
        bad++; $display("FAIL stall_hold_%0d: ready=%b valid=%b data=%h want 0 1 a5", k, o_ready, o_valid, o_data);
      end
    end
    tick(1, 32'hFF, 1, 0);
    total++; if (o_data !== 32'h3C || o_ready !== 1'b1) begin
      bad++; $display("FAIL stall_release1: data=%h ready=%b want 3c 1", o_data, o_ready);
    end
    tick(1, 32'hFF, 1, 0);
    total++; if (o_data !== 32'hFF || o_valid !== 1'b1) begin
      bad++; $display("FAIL stall_release2: data=%h valid=%b want ff 1", o_data, o_valid);
    end
    tick(0, 0, 1, 0);
    total++; if (o_valid !== 1'b0) begin
      bad++; $display("FAIL stall_drain: valid=%b want 0", o_valid);
    end
  endtask

  task automatic test_simultaneous;
    tick(1, 32'h55, 0, 0);
    tick(1, 32'h66, 1, 0);
    total++; if (o_data !== 32'h66 || o_valid !== 1'b1 || o_ready !== 1'b1) begin
      bad++; $display("FAIL simul: data=%h valid=%b ready=%b want 66 1 1", o_data, o_valid, o_ready);
    end
    tick(0, 0, 1, 0);
    total++; if (o_valid !== 1'b0) begin
      bad++; $display("FAIL simul_drain: valid=%b want 0", o_valid);
    end
  endtask

  task automatic test_flush;
    tick(1, 32'h01, 0, 0);
    tick(1, 32'h02, 0, 0);
    tick(1, 32'h03, 0, 1);
    total++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      bad++; $display("FAIL flush: valid=%b ready=%b want 0 1", o_valid, o_ready);
    end
    tick(0, 0, 1, 0);
    total++; if (o_valid !== 1'b0) begin
      bad++; $display("FAIL flush_drop: valid=%b data=%h want valid 0", o_valid, o_data);
    end
  endtask

  task automatic test_random_order;
    int errs = 0;
    int emitted = 0;
    logic v, r, f;
    for (int k = 0; k < 1000; k++) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      f = ($urandom_range(0, 63) == 0);
      if (o_valid && r) emitted++;
      tick(v, $urandom, r, f);
      total++;
      if (o_valid !== (mq.size() > 0) || o_ready !== (mq.size() < 2) ||
          (mq.size() > 0 && o_data !== mq[0])) begin
        bad++; errs++;
        if (errs < 10)
          $display("FAIL random_%0d: valid=%b ready=%b data=%h want valid=%b ready=%b data=%h",
                   k, o_valid, o_ready, o_data, mq.size() > 0, mq.size() < 2,
                   (mq.size() > 0) ? mq[0] : 32'h0);
      end
    end
    total++; if (emitted == 0) begin
      bad++; $display("FAIL random_activity: emitted=%0d want >0", emitted);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall_fill();
    test_simultaneous();
    test_flush();
    test_random_order();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
